// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// It holds a registered result per accepted op and rotates priority on ties.

`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_arbiter (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [`ALU_OP_WIDTH-1:0]     req0_op_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] req0_a_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] req0_b_i,
  input  logic [`ALU_OP_WIDTH-1:0]     req1_op_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] req1_a_i,
  input  logic [`RISCV_WORD_WIDTH-1:0] req1_b_i,
  output logic [1:0]                   rsp_valid_o,
  input  logic [1:0]                   rsp_ready_i,
  output logic [`RISCV_WORD_WIDTH-1:0] rsp_data_o,
  output logic [`ALU_OP_WIDTH-1:0]     alu_op_o,
  output logic [`RISCV_WORD_WIDTH-1:0] alu_operand_a_o,
  output logic [`RISCV_WORD_WIDTH-1:0] alu_operand_b_o,
  input  logic [`RISCV_WORD_WIDTH-1:0] alu_result_i
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_next;
  logic   owner;
  logic   last_grant;
  logic   gnt;
  logic   gnt_valid;
  logic   accept_open;
  logic   accept;

  // Ties go to the port that did not win last time, so neither side starves.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    gnt       = 1'b0;
    gnt_valid = 1'b1;
    unique case (req_valid_i)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt_valid = 1'b0;
    endcase
  end

  // A held response being consumed frees the slot in the same cycle.
  assign accept_open = (state == IDLE) || rsp_ready_i[owner];
  assign accept      = accept_open && gnt_valid;

  always_comb begin
    state_next      = state;
    req_ready_o     = 2'b00;
    rsp_valid_o     = 2'b00;
    alu_op_o        = '0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;

    if (accept) begin
      state_next       = RESP;
      req_ready_o[gnt] = 1'b1;
      alu_op_o         = gnt ? req1_op_i : req0_op_i;
      alu_operand_a_o  = gnt ? req1_a_i  : req0_a_i;
      alu_operand_b_o  = gnt ? req1_b_i  : req0_b_i;
    end else if (state == RESP && rsp_ready_i[owner]) begin
      state_next = IDLE;
    end

    if (state == RESP) rsp_valid_o[owner] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_data_o <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      rsp_data_o <= alu_result_i;
      owner      <= gnt;
      last_grant <= gnt;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
// Inputs change 1ns after each rising edge; outputs are checked 1ns later.

`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_alu_arbiter;
  localparam int W  = `RISCV_WORD_WIDTH;
  localparam int OW = `ALU_OP_WIDTH;

  localparam logic [OW-1:0] OP_ADD = 4'd0;
  localparam logic [OW-1:0] OP_SUB = 4'd1;
  localparam logic [OW-1:0] OP_LTU = 4'd2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [OW-1:0] req0_op_i, req1_op_i, alu_op_o;
  logic [W-1:0]  req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [W-1:0]  rsp_data_o, alu_operand_a_o, alu_operand_b_o, alu_result_i;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req0_op_i(req0_op_i), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
    .req1_op_i(req1_op_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .alu_op_o(alu_op_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .alu_result_i(alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  // Shared ALU model; unknown ops return a^b.
  always_comb begin
    unique case (alu_op_o)
      OP_ADD:  alu_result_i = alu_operand_a_o + alu_operand_b_o;
      OP_SUB:  alu_result_i = alu_operand_a_o - alu_operand_b_o;
      OP_LTU:  alu_result_i = (alu_operand_a_o < alu_operand_b_o) ? W'(1) : W'(0);
      default: alu_result_i = alu_operand_a_o ^ alu_operand_b_o;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 2'b00; rsp_ready_i = 2'b00;
    req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
    req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;

    // Reset state
    repeat (2) step();
    settle();
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    check("rst_rsp_data",  64'(rsp_data_o),  64'h0);
    check("rst_req_ready", 64'(req_ready_o), 64'h0);
    rst_i = 1'b0;

    // Single op: port 0 ADD 5+7
    step();
    req_valid_i = 2'b01; req0_op_i = OP_ADD; req0_a_i = 5; req0_b_i = 7; rsp_ready_i = 2'b01;
    settle();
    check("single_req_ready", 64'(req_ready_o), 64'h1);
    check("single_alu_op",    64'(alu_op_o), 64'(OP_ADD));
    check("single_alu_a",     64'(alu_operand_a_o), 64'd5);
    check("single_alu_b",     64'(alu_operand_b_o), 64'd7);
    step();
    req_valid_i = 2'b00;
    settle();
    check("single_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("single_rsp_data",  64'(rsp_data_o), 64'd12);
    check("single_alu_idle",  64'(alu_operand_a_o), 64'd0);
    step();
    settle();
    check("single_idle", 64'(rsp_valid_o), 64'h0);

    // Tie after reset: port 0 SUB 10-3 first, then port 1 LTU 2<9
    rst_i = 1'b1; settle(); rst_i = 1'b0;
    step();
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    req0_op_i = OP_SUB; req0_a_i = 10; req0_b_i = 3;
    req1_op_i = OP_LTU; req1_a_i = 2;  req1_b_i = 9;
    settle();
    check("tie_first_grant", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i = 2'b10;
    settle();
    check("tie_rsp0_valid",   64'(rsp_valid_o), 64'h1);
    check("tie_rsp0_data",    64'(rsp_data_o), 64'd7);
    check("tie_second_grant", 64'(req_ready_o), 64'h2);
    step();
    req_valid_i = 2'b00;
    settle();
    check("tie_rsp1_valid", 64'(rsp_valid_o), 64'h2);
    check("tie_rsp1_data",  64'(rsp_data_o), 64'd1);

    // Backpressure: port 1 response held, port 0 waits
    rsp_ready_i = 2'b00;
    req_valid_i = 2'b01; req0_op_i = OP_ADD; req0_a_i = 1; req0_b_i = 2;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_req_ready", 64'(req_ready_o), 64'h0);
      check("bp_rsp_valid", 64'(rsp_valid_o), 64'h2);
      check("bp_rsp_data",  64'(rsp_data_o), 64'd1);
      step();
    end
    rsp_ready_i = 2'b10;
    settle();
    check("bp_release_grant", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i = 2'b00;
    settle();
    check("bp_rsp_valid_new", 64'(rsp_valid_o), 64'h1);
    check("bp_rsp_data_new",  64'(rsp_data_o), 64'd3);

    // Non-owner ready ignored: owner 0, rsp_ready_i=10, port 1 waiting
    rsp_ready_i = 2'b10;
    req_valid_i = 2'b10; req1_op_i = OP_ADD; req1_a_i = 4; req1_b_i = 4;
    settle();
    check("nonown_req_ready", 64'(req_ready_o), 64'h0);
    step();
    settle();
    check("nonown_rsp_valid", 64'(rsp_valid_o), 64'h1);
    check("nonown_rsp_data",  64'(rsp_data_o), 64'd3);
    rsp_ready_i = 2'b01;
    settle();
    check("nonown_release_grant", 64'(req_ready_o), 64'h2);
    step();
    settle();
    check("nonown_rsp1_valid", 64'(rsp_valid_o), 64'h2);
    check("nonown_rsp1_data",  64'(rsp_data_o), 64'd8);

    // Fairness: both valid, 8 accepts alternate starting with port 0
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    req0_op_i = OP_ADD; req0_a_i = 32'h10; req0_b_i = 32'h1;
    req1_op_i = OP_SUB; req1_a_i = 32'h30; req1_b_i = 32'h8;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("fair_grant", 64'(req_ready_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      step();
      check("fair_rsp_valid", 64'(rsp_valid_o), (i % 2 == 0) ? 64'h1 : 64'h2);
      check("fair_rsp_data",  64'(rsp_data_o),  (i % 2 == 0) ? 64'h11 : 64'h28);
    end
    req_valid_i = 2'b00;
    step();
    settle();
    check("fair_drain_idle", 64'(rsp_valid_o), 64'h0);

    // Unknown op forwarded unchanged
    req_valid_i = 2'b01; req0_op_i = 4'hA; req0_a_i = 32'hF0; req0_b_i = 32'h0F;
    settle();
    check("fwd_alu_op", 64'(alu_op_o), 64'hA);
    step();
    req_valid_i = 2'b00;
    settle();
    check("fwd_rsp_data", 64'(rsp_data_o), 64'hFF);
    step();

    // Reset mid-RESP: port 1 holds a response, async reset discards it
    req_valid_i = 2'b10; req1_op_i = OP_SUB; req1_a_i = 9; req1_b_i = 4; rsp_ready_i = 2'b00;
    step();
    req_valid_i = 2'b00;
    settle();
    check("armid_rsp_valid", 64'(rsp_valid_o), 64'h2);
    check("armid_rsp_data",  64'(rsp_data_o), 64'd5);
    rst_i = 1'b1;
    settle();
    check("armid_rst_valid", 64'(rsp_valid_o), 64'h0);
    check("armid_rst_data",  64'(rsp_data_o), 64'h0);
    rst_i = 1'b0;
    req_valid_i = 2'b11; rsp_ready_i = 2'b11;
    req0_op_i = OP_ADD; req0_a_i = 2; req0_b_i = 2;
    settle();
    check("armid_tie_grant", 64'(req_ready_o), 64'h1);
    step();
    req_valid_i = 2'b00;
    settle();
    check("armid_tie_rsp", 64'(rsp_valid_o), 64'h1);
    check("armid_tie_data", 64'(rsp_data_o), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
